// File: rtl/rom_chip_defs.sv
// Shared definitions for the fuse-PROM reader/programmer: chip types,
// active-low select vectors, default bus widths and the programmer FSM encoding.
package rom_chip_defs;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;

    localparam logic CHIP_IP3601 = 1'b0;
    localparam logic CHIP_IP3604 = 1'b1;

    localparam logic [1:0] SEL3601_IDLE   = 2'b11;
    localparam logic [1:0] SEL3601_ACTIVE = 2'b00;
    localparam logic [3:0] SEL3604_IDLE   = 4'b1111;
    localparam logic [3:0] SEL3604_ACTIVE = 4'b0000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP,
        ST_READ,
        ST_CHECK,
        ST_ARM,
        ST_PULSE,
        ST_RECOVER,
        ST_VERIFY,
        ST_DONE,
        ST_ERROR
    } prog_state_e;

endpackage

// File: rtl/rom_fuse_programmer_if.sv
// Request and chip-pin bundle of the fuse programmer. The master side issues
// requests and returns chip readback; the slave side is the programmer itself.
interface rom_fuse_programmer_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic                  chip_type;
    logic [ADDR_WIDTH-1:0] address_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] chip_data_port;
    logic [ADDR_WIDTH-1:0] chip_address_port;
    logic [1:0]            ip3601_selection_port;
    logic [3:0]            ip3604_selection_port;
    logic [DATA_WIDTH-1:0] program_bit_port;
    logic                  program_voltage_enable;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [2:0]            error_bit;

    modport master (
        output start, chip_type, address_in, data_in, chip_data_port,
        input  chip_address_port, ip3601_selection_port, ip3604_selection_port,
               program_bit_port, program_voltage_enable, busy, done, error, error_bit
    );

    modport slave (
        input  start, chip_type, address_in, data_in, chip_data_port,
        output chip_address_port, ip3601_selection_port, ip3604_selection_port,
               program_bit_port, program_voltage_enable, busy, done, error, error_bit
    );
endinterface

// File: rtl/rom_pulse_timer.sv
// Loadable down-counter with a zero flag; a load of N-1 holds the caller's
// state for exactly N cycles.
module rom_pulse_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rom_fuse_programmer.sv
// Burns one byte into an IP3601/IP3604 fuse PROM one bit at a time, verifying
// each pulse by readback and retrying a bounded number of times.
module rom_fuse_programmer
    import rom_chip_defs::*;
#(
    parameter int ADDR_WIDTH     = ADDR_W,
    parameter int DATA_WIDTH     = DATA_W,
    parameter int SETTLE_CYCLES  = 4,
    parameter int PULSE_CYCLES   = 50,
    parameter int RECOVER_CYCLES = 8,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    rom_fuse_programmer_if.slave bus
);

    localparam int MAX_CYC = (SETTLE_CYCLES > PULSE_CYCLES)
                           ? ((SETTLE_CYCLES > RECOVER_CYCLES) ? SETTLE_CYCLES : RECOVER_CYCLES)
                           : ((PULSE_CYCLES > RECOVER_CYCLES) ? PULSE_CYCLES : RECOVER_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int RTY_W   = $clog2(MAX_RETRIES + 2);

    prog_state_e           state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] rb_q;
    logic [2:0]            bit_q;
    logic [RTY_W-1:0]      retry_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            sel01_q;
    logic [3:0]            sel04_q;
    logic [DATA_WIDTH-1:0] prog_q;
    logic                  pve_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic [2:0]            error_bit_q;

    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_val;
    logic                  tmr_zero;
    logic [DATA_WIDTH-1:0] rb_extra;
    logic [DATA_WIDTH-1:0] rb_need;
    logic [DATA_WIDTH-1:0] vf_extra;

    function automatic logic [2:0] lowest_set(input logic [DATA_WIDTH-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] onehot(input logic [2:0] b);
        return DATA_WIDTH'(1) << b;
    endfunction

    // Blown fuses outside the target byte can never be cleared, so they are fatal.
    assign rb_extra = rb_q & ~data_q;
    assign rb_need  = data_q & ~rb_q;
    assign vf_extra = bus.chip_data_port & ~data_q;

    // Untimed states keep the timer preloaded so the next timed state starts counting at once.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE, ST_READ, ST_CHECK, ST_VERIFY: begin
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(SETTLE_CYCLES - 1);
            end
            ST_ARM: begin
                tmr_load = tmr_zero;
                tmr_val  = CNT_W'(PULSE_CYCLES - 1);
            end
            ST_PULSE: begin
                tmr_load = tmr_zero;
                tmr_val  = CNT_W'(RECOVER_CYCLES - 1);
            end
            default: ;
        endcase
    end

    rom_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            rb_q        <= '0;
            bit_q       <= '0;
            retry_q     <= '0;
            addr_q      <= '0;
            sel01_q     <= SEL3601_IDLE;
            sel04_q     <= SEL3604_IDLE;
            prog_q      <= '0;
            pve_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            error_bit_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        data_q      <= bus.data_in;
                        addr_q      <= bus.address_in;
                        bit_q       <= '0;
                        retry_q     <= '0;
                        busy_q      <= 1'b1;
                        error_q     <= 1'b0;
                        error_bit_q <= '0;
                        if (bus.chip_type == CHIP_IP3604) sel04_q <= SEL3604_ACTIVE;
                        else                              sel01_q <= SEL3601_ACTIVE;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_zero) state_q <= ST_READ;
                end
                ST_READ: begin
                    rb_q    <= bus.chip_data_port;
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (rb_extra != '0) begin
                        error_bit_q <= lowest_set(rb_extra);
                        error_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        sel01_q     <= SEL3601_IDLE;
                        sel04_q     <= SEL3604_IDLE;
                        state_q     <= ST_ERROR;
                    end else if (rb_need == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        sel01_q <= SEL3601_IDLE;
                        sel04_q <= SEL3604_IDLE;
                        state_q <= ST_DONE;
                    end else begin
                        bit_q   <= lowest_set(rb_need);
                        prog_q  <= onehot(lowest_set(rb_need));
                        retry_q <= '0;
                        state_q <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (tmr_zero) begin
                        pve_q   <= 1'b1;
                        state_q <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (tmr_zero) begin
                        pve_q   <= 1'b0;
                        prog_q  <= '0;
                        state_q <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    if (tmr_zero) state_q <= ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (vf_extra != '0) begin
                        error_bit_q <= lowest_set(vf_extra);
                        error_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        sel01_q     <= SEL3601_IDLE;
                        sel04_q     <= SEL3604_IDLE;
                        state_q     <= ST_ERROR;
                    end else if (bus.chip_data_port[bit_q]) begin
                        rb_q    <= bus.chip_data_port;
                        state_q <= ST_CHECK;
                    end else if (retry_q < RTY_W'(MAX_RETRIES)) begin
                        retry_q <= retry_q + RTY_W'(1);
                        prog_q  <= onehot(bit_q);
                        state_q <= ST_ARM;
                    end else begin
                        error_bit_q <= bit_q;
                        error_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        sel01_q     <= SEL3601_IDLE;
                        sel04_q     <= SEL3604_IDLE;
                        state_q     <= ST_ERROR;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_ERROR: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.chip_address_port      = addr_q;
    assign bus.ip3601_selection_port  = sel01_q;
    assign bus.ip3604_selection_port  = sel04_q;
    assign bus.program_bit_port       = prog_q;
    assign bus.program_voltage_enable = pve_q;
    assign bus.busy                   = busy_q;
    assign bus.done                   = done_q;
    assign bus.error                  = error_q;
    assign bus.error_bit              = error_bit_q;

endmodule

// File: tb/tb_rom_fuse_programmer.sv
// Directed bench for rom_fuse_programmer with a behavioural fuse-PROM model
// that blows the strobed bits when a programming pulse ends.
module tb_rom_fuse_programmer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wipe = 1'b0;
    always #5 clk = ~clk;

    rom_fuse_programmer_if #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) bus ();

    rom_fuse_programmer dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    logic [7:0] preload [0:511];
    logic [7:0] burned  [0:511];
    logic [7:0] ignore_mask = 8'h00;
    logic [1:0] exp01 = 2'b11;
    logic [3:0] exp04 = 4'hF;
    logic [8:0] expaddr = '0;

    logic       in_pulse;
    int         hi_cnt;
    logic [7:0] cur_prog;
    int         npulse;
    logic [7:0] pbit [0:31];
    int         plen [0:31];
    int         vbad;
    int         selbad;

    int n_cmp = 0;
    int n_bad = 0;

    assign bus.chip_data_port = preload[bus.chip_address_port] | burned[bus.chip_address_port];

    // Chip model, sampled on the falling edge.
    always @(negedge clk) begin
        if (wipe) begin
            for (int i = 0; i < 512; i++) burned[i] <= 8'h00;
            npulse <= 0;
            vbad   <= 0;
            selbad <= 0;
        end
        if (!rst_n) begin
            in_pulse <= 1'b0;
            hi_cnt   <= 0;
        end else if (bus.program_voltage_enable) begin
            in_pulse <= 1'b1;
            hi_cnt   <= hi_cnt + 1;
            cur_prog <= bus.program_bit_port;
            if (bus.program_bit_port == 8'h00) vbad <= vbad + 1;
        end else if (in_pulse) begin
            in_pulse     <= 1'b0;
            hi_cnt       <= 0;
            pbit[npulse] <= cur_prog;
            plen[npulse] <= hi_cnt;
            npulse       <= npulse + 1;
            burned[bus.chip_address_port] <= burned[bus.chip_address_port] | (cur_prog & ~ignore_mask);
        end
        if (!wipe && bus.busy && (bus.ip3601_selection_port !== exp01 ||
            bus.ip3604_selection_port !== exp04 || bus.chip_address_port !== expaddr))
            selbad <= selbad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic t, input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        exp01   = (t == 1'b0) ? 2'b00 : 2'b11;
        exp04   = (t == 1'b1) ? 4'h0 : 4'hF;
        expaddr = a;
        bus.chip_type  = t;
        bus.address_in = a;
        bus.data_in    = d;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_end(input int budget, inout int cyc, output bit got_done, output bit got_err);
        got_done = 1'b0;
        got_err  = 1'b0;
        while (cyc < budget) begin
            if (bus.done)  begin got_done = 1'b1; break; end
            if (bus.error) begin got_err  = 1'b1; break; end
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int  cyc;
        int  base;
        bit  gd;
        bit  ge;
        bit  seen;

        for (int i = 0; i < 512; i++) preload[i] = 8'h00;
        bus.start      = 1'b0;
        bus.chip_type  = 1'b0;
        bus.address_in = '0;
        bus.data_in    = '0;
        wipe  = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(bus.busy), 32'h0);
        chk("rst_done",  32'(bus.done), 32'h0);
        chk("rst_error", 32'(bus.error), 32'h0);
        chk("rst_ebit",  32'(bus.error_bit), 32'h0);
        chk("rst_pve",   32'(bus.program_voltage_enable), 32'h0);
        chk("rst_prog",  32'(bus.program_bit_port), 32'h0);
        chk("rst_addr",  32'(bus.chip_address_port), 32'h0);
        chk("rst_sel01", 32'(bus.ip3601_selection_port), 32'h3);
        chk("rst_sel04", 32'(bus.ip3604_selection_port), 32'hF);
        wipe  = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Blank chip, two bits on IP3604
        base = npulse;
        start_op(1'b1, 9'h1A5, 8'h81);
        cyc = 1;
        wait_end(400, cyc, gd, ge);
        chk("t1_done",     32'(gd), 32'h1);
        chk("t1_latency",  32'(cyc), 32'd135);
        chk("t1_busy",     32'(bus.busy), 32'h0);
        chk("t1_addr",     32'(bus.chip_address_port), 32'h1A5);
        chk("t1_sel01",    32'(bus.ip3601_selection_port), 32'h3);
        chk("t1_sel04",    32'(bus.ip3604_selection_port), 32'hF);
        chk("t1_npulse",   32'(npulse - base), 32'd2);
        chk("t1_p0_bit",   32'(pbit[base]), 32'h01);
        chk("t1_p0_len",   32'(plen[base]), 32'd50);
        chk("t1_p1_bit",   32'(pbit[base+1]), 32'h80);
        chk("t1_p1_len",   32'(plen[base+1]), 32'd50);
        chk("t1_readback", 32'(preload[9'h1A5] | burned[9'h1A5]), 32'h81);
        @(negedge clk);
        chk("t1_done_pulse", 32'(bus.done), 32'h0);

        // Partially programmed chip on IP3601
        preload[9'h0A0] = 8'h04;
        base = npulse;
        start_op(1'b0, 9'h0A0, 8'h05);
        cyc = 1;
        wait_end(400, cyc, gd, ge);
        chk("t2_done",     32'(gd), 32'h1);
        chk("t2_latency",  32'(cyc), 32'd71);
        chk("t2_npulse",   32'(npulse - base), 32'd1);
        chk("t2_p0_bit",   32'(pbit[base]), 32'h01);
        chk("t2_readback", 32'(preload[9'h0A0] | burned[9'h0A0]), 32'h05);

        // Fuse already blown outside the target byte
        preload[9'h010] = 8'h02;
        base = npulse;
        start_op(1'b0, 9'h010, 8'h01);
        cyc = 1;
        wait_end(400, cyc, gd, ge);
        chk("t3_error",   32'(ge), 32'h1);
        chk("t3_latency", 32'(cyc), 32'd7);
        chk("t3_ebit",    32'(bus.error_bit), 32'h1);
        chk("t3_busy",    32'(bus.busy), 32'h0);
        chk("t3_npulse",  32'(npulse - base), 32'd0);
        repeat (3) @(negedge clk);
        chk("t3_error_held", 32'(bus.error), 32'h1);

        // Bit 3 never takes: first pulse plus all retries, then error
        ignore_mask = 8'h08;
        base = npulse;
        start_op(1'b1, 9'h033, 8'h08);
        cyc = 1;
        wait_end(600, cyc, gd, ge);
        chk("t4_error",   32'(ge), 32'h1);
        chk("t4_latency", 32'(cyc), 32'd259);
        chk("t4_ebit",    32'(bus.error_bit), 32'h3);
        chk("t4_npulse",  32'(npulse - base), 32'd4);
        chk("t4_p3_bit",  32'(pbit[base+3]), 32'h08);
        chk("t4_p3_len",  32'(plen[base+3]), 32'd50);
        ignore_mask = 8'h00;

        // Reset in the middle of a pulse
        start_op(1'b1, 9'h044, 8'h10);
        chk("t5_error_cleared", 32'(bus.error), 32'h0);
        chk("t5_busy",          32'(bus.busy), 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.program_voltage_enable) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk("t5_pulse_seen", 32'(seen), 32'h1);
        repeat (19) @(negedge clk);
        chk("t5_pve_c20", 32'(bus.program_voltage_enable), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_pve",   32'(bus.program_voltage_enable), 32'h0);
        chk("t5_rst_prog",  32'(bus.program_bit_port), 32'h0);
        chk("t5_rst_busy",  32'(bus.busy), 32'h0);
        chk("t5_rst_sel01", 32'(bus.ip3601_selection_port), 32'h3);
        chk("t5_rst_sel04", 32'(bus.ip3604_selection_port), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = npulse;
        start_op(1'b1, 9'h044, 8'h10);
        cyc = 1;
        wait_end(400, cyc, gd, ge);
        chk("t5_done",     32'(gd), 32'h1);
        chk("t5_latency",  32'(cyc), 32'd71);
        chk("t5_npulse",   32'(npulse - base), 32'd1);
        chk("t5_p0_bit",   32'(pbit[base]), 32'h10);
        chk("t5_readback", 32'(preload[9'h044] | burned[9'h044]), 32'h10);

        // start while busy, with new inputs, is ignored
        base = npulse;
        start_op(1'b0, 9'h055, 8'h02);
        cyc = 1;
        repeat (9) begin @(negedge clk); cyc++; end
        bus.chip_type  = 1'b1;
        bus.address_in = 9'h100;
        bus.data_in    = 8'hFF;
        bus.start      = 1'b1;
        @(negedge clk);
        cyc++;
        bus.start = 1'b0;
        wait_end(400, cyc, gd, ge);
        chk("t6_done",      32'(gd), 32'h1);
        chk("t6_latency",   32'(cyc), 32'd71);
        chk("t6_npulse",    32'(npulse - base), 32'd1);
        chk("t6_readback",  32'(preload[9'h055] | burned[9'h055]), 32'h02);
        chk("t6_untouched", 32'(preload[9'h100] | burned[9'h100]), 32'h00);
        @(negedge clk);
        chk("t6_idle_after", 32'(bus.busy), 32'h0);

        // Nothing to burn
        base = npulse;
        start_op(1'b0, 9'h060, 8'h00);
        cyc = 1;
        wait_end(100, cyc, gd, ge);
        chk("t7_done",    32'(gd), 32'h1);
        chk("t7_latency", 32'(cyc), 32'd7);
        chk("t7_npulse",  32'(npulse - base), 32'd0);

        chk("volt_without_strobe", 32'(vbad), 32'd0);
        chk("pins_while_busy",     32'(selbad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
